// File: rtl/burst_mem_responder.sv
// burst_mem_responder: target end of the cache lowmem burst port.
// Word-addressed RAM serving single/burst reads and writes after LATENCY waits.
// Ports: clk, rst (async high), a (byte addr), d (wdata), we, rd, burst_en,
//   burst_length (words-1), spo (rdata, valid with ready), ready (word strobe).
// Option: define BURST_RESP_WRAP_EN for wrap-in-aligned-block burst addressing.
module burst_mem_responder #(
  parameter int MEM_WORDS = 16384,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] d,
  input  logic        we,
  input  logic        rd,
  input  logic        burst_en,
  input  logic [7:0]  burst_length,
  output logic [31:0] spo,
  output logic        ready
);

  localparam int ADDR_W = $clog2(MEM_WORDS);
  localparam logic [7:0] LAT_LAST = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER,
    DONE
  } state_t;

  logic [31:0] mem [MEM_WORDS];

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n, ptr_inc;
  logic [7:0]        cnt, cnt_n;
  logic [7:0]        wcnt, wcnt_n;
  logic              dir, dir_n;
  logic              ready_n;
  logic              mem_we;
  logic              req;
  logic              unused_a;

  assign req      = rd | we;
  assign unused_a = ^{a[31:ADDR_W+2], a[1:0]};

`ifdef BURST_RESP_WRAP_EN
  // Low bits covered by the block mask roll over inside the block.
  logic [ADDR_W-1:0] wmask, wmask_n;

  assign ptr_inc = (ptr & ~wmask) | ((ptr + ADDR_W'(1)) & wmask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wmask <= '0;
    else     wmask <= wmask_n;
  end

  always_comb begin
    wmask_n = wmask;
    if (state == IDLE && req)
      wmask_n = ADDR_W'(burst_en ? burst_length : 8'd0);
  end
`else
  assign ptr_inc = ptr + ADDR_W'(1);
`endif

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    wcnt_n  = wcnt;
    dir_n   = dir;
    ready_n = 1'b0;
    mem_we  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          ptr_n  = a[ADDR_W+1:2];
          cnt_n  = burst_en ? burst_length : 8'd0;
          dir_n  = we;
          wcnt_n = 8'd0;
          if (LATENCY == 0) begin
            state_n = XFER;
            ready_n = 1'b1;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_n = IDLE;
        end else begin
          wcnt_n = wcnt + 8'd1;
          if (wcnt == LAT_LAST) begin
            state_n = XFER;
            ready_n = 1'b1;
          end
        end
      end
      XFER: begin
        if (!req) begin
          state_n = IDLE;
        end else begin
          mem_we = dir;
          if (cnt == 8'd0) begin
            state_n = DONE;
          end else begin
            cnt_n   = cnt - 8'd1;
            ptr_n   = ptr_inc;
            ready_n = 1'b1;
          end
        end
      end
      DONE: begin
        if (!req) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      wcnt  <= '0;
      dir   <= 1'b0;
      ready <= 1'b0;
      spo   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      wcnt  <= wcnt_n;
      dir   <= dir_n;
      ready <= ready_n;
      // Prefetch so read data lines up with the registered ready strobe.
      if (ready_n && !dir_n)
        spo <= mem[ptr_n];
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[ptr] <= d;
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// tb_burst_mem_responder: directed checks of burst_mem_responder.
// Two instances: LATENCY=2 (default) and LATENCY=0, sharing request inputs.
module tb_burst_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] d = '0;
  logic        we = 1'b0;
  logic        rd = 1'b0;
  logic        burst_en = 1'b0;
  logic [7:0]  burst_length = '0;
  logic [31:0] spo2, spo0;
  logic        ready2, ready0;
  logic        sel = 1'b0;
  logic [31:0] spo_m;
  logic        ready_m;

  int total = 0;
  int bad = 0;

  logic [31:0] got [$];
  int first_c, nrdy;
  logic gapless, tout;

  always #5 clk = ~clk;

  assign spo_m   = sel ? spo0 : spo2;
  assign ready_m = sel ? ready0 : ready2;

  burst_mem_responder #(.MEM_WORDS(16384), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .rd(rd),
    .burst_en(burst_en), .burst_length(burst_length),
    .spo(spo2), .ready(ready2)
  );

  burst_mem_responder #(.MEM_WORDS(16384), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .rd(rd),
    .burst_en(burst_en), .burst_length(burst_length),
    .spo(spo0), .ready(ready0)
  );

  // Drives one transaction; cycle 0 is the cycle the request is first seen.
  task automatic run_txn(
    input logic w, input logic r, input logic [31:0] addr,
    input logic be, input logic [7:0] len, input logic [31:0] dbase,
    input int abort_at, input int hold
  );
    int c, last, words;
    words = be ? int'(len) + 1 : 1;
    c = 0; last = -1;
    first_c = -1; nrdy = 0; tout = 1'b0; gapless = 1'b0;
    got.delete();
    @(posedge clk); #1;
    a = addr; we = w; rd = r; burst_en = be;
    burst_length = len; d = dbase;
    forever begin
      @(negedge clk);
      if (ready_m) begin
        if (first_c < 0) first_c = c;
        last = c;
        nrdy++;
        got.push_back(spo_m);
      end
      @(posedge clk); #1;
      c++;
      d = dbase + nrdy;
      if (abort_at >= 0 && nrdy == abort_at) break;
      if (abort_at < 0 && nrdy == words) break;
      if (c > 600) begin
        tout = 1'b1;
        break;
      end
    end
    gapless = (nrdy > 0) && (last - first_c + 1 == nrdy);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ready_m) nrdy++;
      @(posedge clk); #1;
    end
    we = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    total++;
    if (ready2 !== 1'b0 || ready0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got=%b/%b want=0", ready2, ready0);
    end
    total++;
    if (spo2 !== 32'h0 || spo0 !== 32'h0) begin
      bad++;
      $display("FAIL reset_spo got=%h/%h want=0", spo2, spo0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single;
    sel = 1'b0;
    run_txn(1'b1, 1'b0, 32'h40, 1'b0, 8'd0, 32'hDEADBEEF, -1, 0);
    total++;
    if (tout || first_c !== 3 || nrdy !== 1) begin
      bad++;
      $display("FAIL single_wr first=%0d n=%0d want first=3 n=1", first_c, nrdy);
    end
    run_txn(1'b0, 1'b1, 32'h40, 1'b0, 8'd0, 32'h0, -1, 0);
    total++;
    if (tout || first_c !== 3 || nrdy !== 1) begin
      bad++;
      $display("FAIL single_rd_lat first=%0d n=%0d want first=3 n=1", first_c, nrdy);
    end
    total++;
    if (got.size() != 1 || got[0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_rd_data got=%h want=deadbeef",
               got.size() > 0 ? got[0] : 32'hx);
    end
  endtask

  task automatic test_burst;
    int errs;
    sel = 1'b0;
    run_txn(1'b1, 1'b0, 32'h1000, 1'b1, 8'd31, 32'h0, -1, 0);
    total++;
    if (tout || nrdy !== 32 || !gapless || first_c !== 3) begin
      bad++;
      $display("FAIL burst_wr n=%0d gapless=%b first=%0d want 32/1/3",
               nrdy, gapless, first_c);
    end
    run_txn(1'b0, 1'b1, 32'h1000, 1'b1, 8'd31, 32'h0, -1, 3);
    total++;
    if (tout || nrdy !== 32 || !gapless || first_c !== 3) begin
      bad++;
      $display("FAIL burst_rd n=%0d gapless=%b first=%0d want 32/1/3",
               nrdy, gapless, first_c);
    end
    errs = 0;
    for (int k = 0; k < 32; k++)
      if (k >= got.size() || got[k] !== 32'(k)) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL burst_rd_data errors=%0d want 0", errs);
    end
  endtask

  task automatic test_wrap;
    int waddr [4];
    int errs;
    sel = 1'b0;
`ifdef BURST_RESP_WRAP_EN
    waddr = '{16382, 16383, 16380, 16381};
`else
    waddr = '{16382, 16383, 0, 1};
`endif
    run_txn(1'b1, 1'b0, 32'(16382 * 4), 1'b1, 8'd3, 32'h100, -1, 0);
    errs = 0;
    for (int k = 0; k < 4; k++) begin
      run_txn(1'b0, 1'b1, 32'(waddr[k] * 4), 1'b0, 8'd0, 32'h0, -1, 0);
      if (tout || got.size() != 1 || got[0] !== 32'h100 + 32'(k)) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL wrap_top errors=%0d want 0", errs);
    end
`ifdef BURST_RESP_WRAP_EN
    waddr = '{6, 7, 4, 5};
    run_txn(1'b1, 1'b0, 32'h18, 1'b1, 8'd3, 32'h200, -1, 0);
    errs = 0;
    for (int k = 0; k < 4; k++) begin
      run_txn(1'b0, 1'b1, 32'(waddr[k] * 4), 1'b0, 8'd0, 32'h0, -1, 0);
      if (tout || got.size() != 1 || got[0] !== 32'h200 + 32'(k)) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL wrap_block errors=%0d want 0", errs);
    end
`endif
  endtask

  task automatic test_abort;
    int errs;
    logic [31:0] exp;
    sel = 1'b0;
    run_txn(1'b1, 1'b0, 32'h2000, 1'b1, 8'd15, 32'hA0, -1, 0);
    run_txn(1'b1, 1'b0, 32'h2000, 1'b1, 8'd15, 32'hB0, 5, 0);
    total++;
    if (tout || nrdy !== 5) begin
      bad++;
      $display("FAIL abort_count n=%0d want 5", nrdy);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (ready_m !== 1'b0) begin
      bad++;
      $display("FAIL abort_ready got=%b want=0", ready_m);
    end
    run_txn(1'b0, 1'b1, 32'h2000, 1'b1, 8'd15, 32'h0, -1, 0);
    total++;
    if (tout || first_c !== 3 || nrdy !== 16) begin
      bad++;
      $display("FAIL abort_idle first=%0d n=%0d want 3/16", first_c, nrdy);
    end
    errs = 0;
    for (int k = 0; k < 16; k++) begin
      exp = (k < 5) ? 32'hB0 + 32'(k) : 32'hA0 + 32'(k);
      if (k >= got.size() || got[k] !== exp) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL abort_data errors=%0d want 0", errs);
    end
  endtask

  task automatic test_rdwe;
    sel = 1'b1;
    run_txn(1'b1, 1'b1, 32'h80, 1'b0, 8'd0, 32'h5A5A5A5A, -1, 6);
    total++;
    if (tout || first_c !== 1) begin
      bad++;
      $display("FAIL rdwe_lat first=%0d want 1", first_c);
    end
    total++;
    if (nrdy !== 1) begin
      bad++;
      $display("FAIL rdwe_retrigger n=%0d want 1", nrdy);
    end
    run_txn(1'b0, 1'b1, 32'h80, 1'b0, 8'd0, 32'h0, -1, 0);
    total++;
    if (tout || first_c !== 1 || got.size() != 1 || got[0] !== 32'h5A5A5A5A) begin
      bad++;
      $display("FAIL rdwe_data first=%0d got=%h want 1/5a5a5a5a",
               first_c, got.size() > 0 ? got[0] : 32'hx);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n;
    n = 0;
    sel = 1'b0;
    @(posedge clk); #1;
    a = 32'h1000; rd = 1'b1; burst_en = 1'b1; burst_length = 8'd31;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (ready_m) n++;
    end
    total++;
    if (n != 4 || spo_m !== 32'd3) begin
      bad++;
      $display("FAIL mid_pre n=%0d spo=%h want 4/3", n, spo_m);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (ready_m !== 1'b0 || spo_m !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset ready=%b spo=%h want 0/0", ready_m, spo_m);
    end
    rd = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    run_txn(1'b0, 1'b1, 32'h40, 1'b0, 8'd0, 32'h0, -1, 0);
    total++;
    if (tout || first_c !== 3 || got.size() != 1 || got[0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL mid_after first=%0d got=%h want 3/deadbeef",
               first_c, got.size() > 0 ? got[0] : 32'hx);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_burst;
    test_wrap;
    test_abort;
    test_rdwe;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
